// File: rtl/irq_pend_if.sv
// Pend request handshake between an interrupt source block and the CLIC.
// master drives valid/index, slave returns ready.
interface irq_pend_if #(
  parameter int IdxWidth = 3
) ();
  logic                pend_valid;
  logic [IdxWidth-1:0] pend_index;
  logic                pend_ready;

  modport master (output pend_valid, output pend_index, input pend_ready);
  modport slave  (input pend_valid, input pend_index, output pend_ready);
endinterface

// File: rtl/irq_pend_gen.sv
// Per-source interrupt event queue delivering one pend request at a time, round-robin.
// Optional IRQ_SYNC_EN: adds a 2-flop synchronizer in front of edge detection for async irq_in.
module irq_pend_gen #(
  parameter int NumSrc   = 8,
  parameter int IdxWidth = $clog2(NumSrc),
  parameter int CntWidth = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumSrc-1:0] irq_in,
  input  logic [NumSrc-1:0] src_enable,
  input  logic [NumSrc-1:0] ovf_clear,
  irq_pend_if.master        pend,
  output logic              pending_any,
  output logic [NumSrc-1:0] overflow
);

  typedef enum logic {IDLE, OFFER} state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [CntWidth-1:0] cnt_q [NumSrc];
  logic [CntWidth-1:0] cnt_d [NumSrc];
  logic [NumSrc-1:0]   ovf_q, ovf_d;
  logic [NumSrc-1:0]   irq_prev_q, irq_prev_d;
  logic [NumSrc-1:0]   irq_s;
  logic [NumSrc-1:0]   ev;
  logic                hs;
  logic [IdxWidth:0]   pick;

  // Returns {overflow_set, next_count}; an edge into a full counter is lost and flagged.
  function automatic logic [CntWidth:0] sat_step(input logic [CntWidth-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CntWidth:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CntMax) r = {1'b1, cnt};
      else               r = {1'b0, cnt + CntWidth'(1)};
    end else if (dec && !inc) begin
      r = {1'b0, cnt - CntWidth'(1)};
    end
    return r;
  endfunction

  // Returns {found, index}: first enabled non-empty source at or above start, wrapping.
  function automatic logic [IdxWidth:0] rr_pick(input logic [IdxWidth-1:0] start,
                                                input logic [NumSrc-1:0]   elig);
    logic [IdxWidth:0] r;
    int j;
    r = '0;
    for (int k = NumSrc - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NumSrc) j = j - NumSrc;
      if (elig[j]) r = {1'b1, IdxWidth'(j)};
    end
    return r;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NumSrc-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  logic [NumSrc-1:0] elig;

  always_comb begin
    irq_prev_d  = irq_s;
    ev          = irq_s & ~irq_prev_q & src_enable;
    hs          = valid_q & pend.pend_ready;
    pending_any = 1'b0;
    elig        = '0;
    for (int i = 0; i < NumSrc; i++) begin
      logic [CntWidth:0] step;
      step     = sat_step(cnt_q[i], ev[i], hs && (idx_q == IdxWidth'(i)));
      cnt_d[i] = step[CntWidth-1:0];
      // A new loss in the same cycle as a clear must stay visible.
      ovf_d[i] = step[CntWidth] | (ovf_q[i] & ~ovf_clear[i]);
      elig[i]  = (cnt_q[i] != '0) && src_enable[i];
      pending_any = pending_any | (cnt_q[i] != '0);
    end
  end

  assign pick = rr_pick(rr_q, elig);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick[IdxWidth]) begin
          idx_d   = pick[IdxWidth-1:0];
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Offer stays frozen until accepted, even if the source is disabled meanwhile.
        if (pend.pend_ready) begin
          valid_d = 1'b0;
          rr_d    = (idx_q == IdxWidth'(NumSrc - 1)) ? '0 : idx_q + IdxWidth'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      rr_q       <= '0;
      ovf_q      <= '0;
      irq_prev_q <= '0;
      for (int i = 0; i < NumSrc; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
      irq_prev_q <= irq_prev_d;
      for (int i = 0; i < NumSrc; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pend.pend_valid = valid_q;
  assign pend.pend_index = idx_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_irq_pend_gen.sv
// Directed bench for irq_pend_gen (default build, IRQ_SYNC_EN undefined).
module tb_irq_pend_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in, src_enable, ovf_clear;
  logic       pending_any;
  logic [7:0] overflow;
  int n_vec = 0;
  int n_err = 0;
  int hs_cnt, bad_idx, ng;
  logic [2:0] grants [3];

  irq_pend_if #(.IdxWidth(3)) pend_if ();

  irq_pend_gen #(.NumSrc(8), .IdxWidth(3), .CntWidth(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .src_enable (src_enable),
    .ovf_clear  (ovf_clear),
    .pend       (pend_if.master),
    .pending_any(pending_any),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    irq_in = '0;
    src_enable = 8'hFF;
    ovf_clear = '0;
    pend_if.pend_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(pend_if.pend_valid), 32'd0);
    check("rst_index", 32'(pend_if.pend_index), 32'd0);
    check("rst_pany", 32'(pending_any), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single event on src 3, ready high
    irq_in[3] = 1'b1;
    pend_if.pend_ready = 1'b1;
    check("t1_c_valid", 32'(pend_if.pend_valid), 32'd0);
    tick();
    check("t1_c1_valid", 32'(pend_if.pend_valid), 32'd0);
    check("t1_c1_pany", 32'(pending_any), 32'd1);
    tick();
    check("t1_c2_valid", 32'(pend_if.pend_valid), 32'd1);
    check("t1_c2_index", 32'(pend_if.pend_index), 32'd3);
    tick();
    check("t1_c3_pany", 32'(pending_any), 32'd0);
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (pend_if.pend_valid) hs_cnt++;
      tick();
    end
    check("t1_no_second", 32'(hs_cnt), 32'd0);
    irq_in = '0;
    tick();

    // 2: nine edges on src 5 with ready low saturate at 7
    pend_if.pend_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      irq_in[5] = 1'b1;
      tick();
      irq_in[5] = 1'b0;
      tick();
    end
    check("t2_cnt5", 32'(dut.cnt_q[5]), 32'd7);
    check("t2_ovf", 32'(overflow), 32'h20);
    pend_if.pend_ready = 1'b1;
    hs_cnt = 0;
    bad_idx = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend_if.pend_valid) begin
        hs_cnt++;
        if (pend_if.pend_index != 3'd5) bad_idx++;
      end
      tick();
    end
    check("t2_hs_count", 32'(hs_cnt), 32'd7);
    check("t2_hs_index", 32'(bad_idx), 32'd0);
    check("t2_pany", 32'(pending_any), 32'd0);
    ovf_clear[5] = 1'b1;
    tick();
    ovf_clear = '0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: grant src 4 to set rr_ptr=5, then srcs 1,4,6 together
    pend_if.pend_ready = 1'b0;
    irq_in[4] = 1'b1;
    tick();
    irq_in[4] = 1'b0;
    tick();
    check("t3_pre_valid", 32'(pend_if.pend_valid), 32'd1);
    check("t3_pre_index", 32'(pend_if.pend_index), 32'd4);
    pend_if.pend_ready = 1'b1;
    tick();
    check("t3_rr5", 32'(dut.rr_q), 32'd5);
    irq_in = 8'b0101_0010;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      if (pend_if.pend_valid && ng < 3) begin
        grants[ng] = pend_if.pend_index;
        ng++;
      end
      tick();
    end
    check("t3_ngrants", 32'(ng), 32'd3);
    check("t3_grant0", 32'(grants[0]), 32'd6);
    check("t3_grant1", 32'(grants[1]), 32'd1);
    check("t3_grant2", 32'(grants[2]), 32'd4);
    check("t3_rr_end", 32'(dut.rr_q), 32'd5);
    irq_in = '0;
    tick();

    // 4: offer for src 2 held through ready low and enable drop
    pend_if.pend_ready = 1'b0;
    irq_in[2] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) src_enable[2] = 1'b0;
      check("t4_hold_valid", 32'(pend_if.pend_valid), 32'd1);
      check("t4_hold_index", 32'(pend_if.pend_index), 32'd2);
      tick();
    end
    pend_if.pend_ready = 1'b1;
    check("t4_acc_valid", 32'(pend_if.pend_valid), 32'd1);
    tick();
    check("t4_after_valid", 32'(pend_if.pend_valid), 32'd0);
    check("t4_rr3", 32'(dut.rr_q), 32'd3);
    check("t4_pany", 32'(pending_any), 32'd0);
    src_enable = 8'hFF;
    irq_in = '0;
    pend_if.pend_ready = 1'b0;
    tick();

    // 5: edge on src 0 in the cycle its single event is handshaken
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick();
    check("t5_offer_index", 32'(pend_if.pend_index), 32'd0);
    pend_if.pend_ready = 1'b1;
    irq_in[0] = 1'b1;
    tick();
    pend_if.pend_ready = 1'b0;
    check("t5_gap_valid", 32'(pend_if.pend_valid), 32'd0);
    check("t5_cnt0", 32'(dut.cnt_q[0]), 32'd1);
    tick();
    check("t5_new_valid", 32'(pend_if.pend_valid), 32'd1);
    check("t5_new_index", 32'(pend_if.pend_index), 32'd0);

    // 6: reset during OFFER, with a queued event and an overflow present
    for (int i = 0; i < 9; i++) begin
      irq_in[7] = 1'b1;
      tick();
      irq_in[7] = 1'b0;
      tick();
    end
    check("t6_pre_ovf", 32'(overflow), 32'h80);
    check("t6_pre_valid", 32'(pend_if.pend_valid), 32'd1);
    reset = 1'b1;
    irq_in = '0;
    #1;
    check("t6_valid_async", 32'(pend_if.pend_valid), 32'd0);
    check("t6_pany", 32'(pending_any), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t6_post_valid", 32'(pend_if.pend_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
